// File: rtl/pc_upstream_arbiter.sv
// pc_upstream_arbiter: merges three upstream word streams (BD, FPGA, global
// route) into one registered stream towards the PC. Weighted round-robin
// bursts; code words can lock the grant onto one source for a group.
module pc_upstream_arbiter #(
    parameter int  NPCroute = 5,
    parameter int  NPCcode  = 7,
    parameter int  NPCdata  = 20,
    parameter int  NWGT     = 4,
    localparam int W        = NPCroute + NPCcode + NPCdata
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    in0_d,
    input  logic            in0_v,
    output logic            in0_a,
    input  logic [W-1:0]    in1_d,
    input  logic            in1_v,
    output logic            in1_a,
    input  logic [W-1:0]    in2_d,
    input  logic            in2_v,
    output logic            in2_a,
    input  logic [NWGT-1:0] wgt0,
    input  logic [NWGT-1:0] wgt1,
    input  logic [NWGT-1:0] wgt2,
    output logic [W-1:0]    out_d,
    output logic            out_v,
    input  logic            out_a,
    output logic [1:0]      cur_src,
    output logic            locked
);

    // Handshake: every channel moves a word in the cycle where v=1 and a=1.
    // Producers hold d/v until accepted; acks never depend on the same
    // channel's a (no combinational loop), only on v, grant and out space.

    localparam logic [NPCcode-1:0] CODE_PAIR   = NPCcode'(14);
    localparam logic [NPCcode-1:0] CODE_LOCK   = NPCcode'(15);
    localparam logic [NPCcode-1:0] CODE_UNLOCK = NPCcode'(16);

    logic [1:0]      r_cur;
    logic [NWGT-1:0] r_credit;
    logic            r_pair;
    logic            r_hb;
    logic            r_out_v;
    logic [W-1:0]    r_out_d;

    logic [3:0]      w_v;
    logic [1:0]      w_n1;
    logic [1:0]      w_n2;
    logic [1:0]      w_g;
    logic            w_ready;
    logic            w_acc;
    logic            w_locked;
    logic [W-1:0]    w_word;
    logic [NWGT-1:0] w_wgt;
    logic [NWGT-1:0] w_credit_load;
    logic [NPCcode-1:0] w_code;

    assign w_v      = {1'b0, in2_v, in1_v, in0_v};
    assign w_n1     = (r_cur == 2'd2) ? 2'd0 : r_cur + 2'd1;
    assign w_n2     = (w_n1 == 2'd2) ? 2'd0 : w_n1 + 2'd1;
    assign w_locked = r_pair | r_hb;

    // Grant decision: lock holds, then remaining burst credit, then rotate.
    always_comb begin
        w_g = r_cur;
        if (w_locked) begin
            w_g = r_cur;
        end else if ((r_credit != '0) && w_v[r_cur]) begin
            w_g = r_cur;
        end else if (w_v[w_n1]) begin
            w_g = w_n1;
        end else if (w_v[w_n2]) begin
            w_g = w_n2;
        end else begin
            w_g = r_cur;
        end
    end

    // Output register has room when empty or draining this cycle; no acks in reset.
    assign w_ready = (!r_out_v | out_a) & reset;
    assign in0_a   = (w_g == 2'd0) & in0_v & w_ready;
    assign in1_a   = (w_g == 2'd1) & in1_v & w_ready;
    assign in2_a   = (w_g == 2'd2) & in2_v & w_ready;
    assign w_acc   = in0_a | in1_a | in2_a;

    // Word and weight of the granted source.
    always_comb begin
        w_word = in2_d;
        w_wgt  = wgt2;
        case (w_g)
            2'd0:    begin w_word = in0_d; w_wgt = wgt0; end
            2'd1:    begin w_word = in1_d; w_wgt = wgt1; end
            default: begin w_word = in2_d; w_wgt = wgt2; end
        endcase
    end

    // A zero weight still grants one word per turn.
    assign w_credit_load = (w_wgt == '0) ? '0 : w_wgt - NWGT'(1);
    assign w_code        = w_word[NPCcode+NPCdata-1:NPCdata];

    // Single-word output register, loaded whenever it has room.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_out_v <= 1'b0;
            r_out_d <= '0;
        end else if (w_ready) begin
            r_out_v <= w_acc;
            if (w_acc) r_out_d <= w_word;
        end
    end

    // Current owner and burst credit; a new owner reloads from its weight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cur    <= 2'd2;
            r_credit <= '0;
        end else if (w_acc) begin
            if (w_g != r_cur) begin
                r_cur    <= w_g;
                r_credit <= w_credit_load;
            end else if (r_credit != '0) begin
                r_credit <= r_credit - NWGT'(1);
            end
        end
    end

    // Group lock tracking from the code field of each accepted word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pair <= 1'b0;
            r_hb   <= 1'b0;
        end else if (w_acc) begin
            if (w_code == CODE_PAIR)   r_pair <= ~r_pair;
            if (w_code == CODE_LOCK)   r_hb   <= 1'b1;
            if (w_code == CODE_UNLOCK) r_hb   <= 1'b0;
        end
    end

    assign out_d   = r_out_d;
    assign out_v   = r_out_v;
    assign cur_src = r_cur;
    assign locked  = w_locked;

endmodule

// File: tb/tb_pc_upstream_arbiter.sv
// Directed testbench for pc_upstream_arbiter: per-source word queues drive
// the inputs, the output stream is collected and compared to hand-derived
// sequences.
module tb_pc_upstream_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in0_d, in1_d, in2_d;
    logic        in0_v, in1_v, in2_v;
    logic        in0_a, in1_a, in2_a;
    logic [3:0]  wgt0, wgt1, wgt2;
    logic [31:0] out_d;
    logic        out_v;
    logic        out_a;
    logic [1:0]  cur_src;
    logic        locked;

    logic [31:0] q0[$], q1[$], q2[$];
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    logic        en0, en1, en2;
    logic        s_a0, s_a1, s_a2, s_locked, s_out_v;
    logic [31:0] s_out_d;
    int          n_checks = 0;
    int          n_fail = 0;

    pc_upstream_arbiter dut (
        .clk(clk), .reset(reset),
        .in0_d(in0_d), .in0_v(in0_v), .in0_a(in0_a),
        .in1_d(in1_d), .in1_v(in1_v), .in1_a(in1_a),
        .in2_d(in2_d), .in2_v(in2_v), .in2_a(in2_a),
        .wgt0(wgt0), .wgt1(wgt1), .wgt2(wgt2),
        .out_d(out_d), .out_v(out_v), .out_a(out_a),
        .cur_src(cur_src), .locked(locked)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mk(input int src, input int code, input int seq);
        return {src[4:0], code[6:0], seq[19:0]};
    endfunction

    task automatic drive();
        in0_v = en0 && (q0.size() > 0);
        in1_v = en1 && (q1.size() > 0);
        in2_v = en2 && (q2.size() > 0);
        in0_d = (q0.size() > 0) ? q0[0] : 32'h0;
        in1_d = (q1.size() > 0) ? q1[0] : 32'h0;
        in2_d = (q2.size() > 0) ? q2[0] : 32'h0;
    endtask

    // One clock: sample at negedge, advance queues for accepted words after posedge.
    task automatic step();
        @(negedge clk);
        s_a0 = in0_a; s_a1 = in1_a; s_a2 = in2_a;
        s_locked = locked; s_out_v = out_v; s_out_d = out_d;
        if (out_v && out_a) obs_q.push_back(out_d);
        @(posedge clk);
        #1;
        if (s_a0 && q0.size() > 0) void'(q0.pop_front());
        if (s_a1 && q1.size() > 0) void'(q1.pop_front());
        if (s_a2 && q2.size() > 0) void'(q2.pop_front());
        drive();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        #1;
        q0.delete(); q1.delete(); q2.delete();
        obs_q.delete(); exp_q.delete();
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        out_a = 1'b1;
        wgt0 = 4'd1; wgt1 = 4'd1; wgt2 = 4'd1;
        drive();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        q0.push_back(mk(0, 0, 0)); q1.push_back(mk(1, 0, 0)); q2.push_back(mk(2, 0, 0));
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        drive();
        @(negedge clk);
        n_checks++; if ({in0_a, in1_a, in2_a} !== 3'b000) begin n_fail++; $display("FAIL reset_acks: got %b expected 000", {in0_a, in1_a, in2_a}); end
        n_checks++; if (out_v !== 1'b0) begin n_fail++; $display("FAIL reset_out_v: got %b expected 0", out_v); end
        n_checks++; if (out_d !== 32'h0) begin n_fail++; $display("FAIL reset_out_d: got %h expected 0", out_d); end
        n_checks++; if (cur_src !== 2'd2) begin n_fail++; $display("FAIL reset_cur_src: got %0d expected 2", cur_src); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked); end
        reset = 1'b1;
        #1;
        n_checks++; if ({in2_a, in1_a, in0_a} !== 3'b001) begin n_fail++; $display("FAIL first_grant: got %b expected 001", {in2_a, in1_a, in0_a}); end
        @(posedge clk);
        #1;
        void'(q0.pop_front());
        drive();
        n_checks++; if (out_v !== 1'b1) begin n_fail++; $display("FAIL latency_out_v: got %b expected 1", out_v); end
        n_checks++; if (out_d !== mk(0, 0, 0)) begin n_fail++; $display("FAIL latency_out_d: got %h expected %h", out_d, mk(0, 0, 0)); end
        n_checks++; if (cur_src !== 2'd0) begin n_fail++; $display("FAIL after_first_cur_src: got %0d expected 0", cur_src); end
    endtask

    task automatic test_weighted();
        int cnt[3];
        int srcs[8];
        apply_reset();
        wgt0 = 4'd2; wgt1 = 4'd1; wgt2 = 4'd1;
        for (int i = 0; i < 12; i++) begin
            q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 0, i)); q2.push_back(mk(2, 0, i));
        end
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        drive();
        srcs = '{0, 0, 1, 2, 0, 0, 1, 2};
        cnt = '{0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(mk(srcs[i], 0, cnt[srcs[i]]));
            cnt[srcs[i]]++;
        end
        repeat (9) step();
        n_checks++; if (obs_q.size() !== 8) begin n_fail++; $display("FAIL weighted_count: got %0d expected 8", obs_q.size()); end
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL weighted_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_pair();
        apply_reset();
        for (int i = 0; i < 3; i++) q0.push_back(mk(0, 0, i));
        q1.push_back(mk(1, 14, 10)); q1.push_back(mk(1, 14, 11));
        en0 = 1'b1; en1 = 1'b1;
        drive();
        exp_q = '{mk(0, 0, 0), mk(1, 14, 10), mk(1, 14, 11), mk(0, 0, 1)};
        repeat (5) step();
        n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL pair_count: got %0d expected 4", obs_q.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pair_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL pair_unlocked: got %b expected 0", locked); end
    endtask

    task automatic test_lock();
        int bad;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 0, i));
        end
        q2.push_back(mk(2, 15, 1));
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        drive();
        step(); step(); step();
        n_checks++; if (s_a2 !== 1'b1) begin n_fail++; $display("FAIL lock_code15_ack: got %b expected 1", s_a2); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (s_a0 !== 1'b0 || s_a1 !== 1'b0 || s_locked !== 1'b1) bad++;
        end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL lock_hold: got %0d bad cycles expected 0", bad); end
        q2.push_back(mk(2, 16, 2));
        drive();
        step();
        n_checks++; if ({s_a2, s_a1, s_a0} !== 3'b100) begin n_fail++; $display("FAIL lock_code16_ack: got %b expected 100", {s_a2, s_a1, s_a0}); end
        n_checks++; if (s_locked !== 1'b1) begin n_fail++; $display("FAIL lock_before16: got %b expected 1", s_locked); end
        step();
        n_checks++; if (s_locked !== 1'b0) begin n_fail++; $display("FAIL lock_released: got %b expected 0", s_locked); end
        n_checks++; if ({s_a2, s_a1, s_a0} !== 3'b001) begin n_fail++; $display("FAIL lock_next_grant: got %b expected 001", {s_a2, s_a1, s_a0}); end
    endtask

    task automatic test_backpressure();
        int acks;
        int bad;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(0, 0, i)); q1.push_back(mk(1, 0, i)); q2.push_back(mk(2, 0, i));
        end
        en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
        out_a = 1'b0;
        drive();
        acks = 0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            acks += int'(s_a0) + int'(s_a1) + int'(s_a2);
            if (i > 0 && (s_out_v !== 1'b1 || s_out_d !== mk(0, 0, 0))) bad++;
        end
        n_checks++; if (acks !== 1) begin n_fail++; $display("FAIL bp_accept_count: got %0d expected 1", acks); end
        n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL bp_out_stable: got %0d bad cycles expected 0", bad); end
        out_a = 1'b1;
        step();
        n_checks++; if (obs_q.size() !== 1 || obs_q[0] !== mk(0, 0, 0)) begin n_fail++; $display("FAIL bp_drained: got %h expected %h", obs_q[0], mk(0, 0, 0)); end
        n_checks++; if ({s_a2, s_a1, s_a0} !== 3'b010) begin n_fail++; $display("FAIL bp_resume_grant: got %b expected 010", {s_a2, s_a1, s_a0}); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        out_a = 1'b0;
        q0.push_back(mk(0, 15, 0)); q0.push_back(mk(0, 0, 1));
        q1.push_back(mk(1, 0, 0));
        en0 = 1'b1; en1 = 1'b1;
        drive();
        step();
        #2;
        n_checks++; if ({out_v, locked} !== 2'b11) begin n_fail++; $display("FAIL mid_pre: got %b expected 11", {out_v, locked}); end
        reset = 1'b0;
        #1;
        n_checks++; if ({out_v, locked} !== 2'b00) begin n_fail++; $display("FAIL mid_async_clear: got %b expected 00", {out_v, locked}); end
        n_checks++; if ({in2_a, in1_a, in0_a} !== 3'b000) begin n_fail++; $display("FAIL mid_acks: got %b expected 000", {in2_a, in1_a, in0_a}); end
        @(negedge clk);
        reset = 1'b1;
        out_a = 1'b1;
        #1;
        n_checks++; if (cur_src !== 2'd2) begin n_fail++; $display("FAIL mid_cur_src: got %0d expected 2", cur_src); end
        n_checks++; if ({in2_a, in1_a, in0_a} !== 3'b001) begin n_fail++; $display("FAIL mid_first_grant: got %b expected 001", {in2_a, in1_a, in0_a}); end
        @(posedge clk);
        #1;
        void'(q0.pop_front());
        drive();
        n_checks++; if (out_d !== mk(0, 0, 1)) begin n_fail++; $display("FAIL mid_out_d: got %h expected %h", out_d, mk(0, 0, 1)); end
    endtask

    task automatic test_zero_weight();
        int acks;
        apply_reset();
        wgt0 = 4'd0;
        for (int i = 0; i < 8; i++) q0.push_back(mk(0, 0, i));
        for (int i = 0; i < 2; i++) q1.push_back(mk(1, 0, i));
        en0 = 1'b1;
        drive();
        acks = 0;
        repeat (5) begin
            step();
            acks += int'(s_a0);
        end
        n_checks++; if (acks !== 5) begin n_fail++; $display("FAIL zw_accepts: got %0d expected 5", acks); end
        n_checks++; if (obs_q.size() !== 4) begin n_fail++; $display("FAIL zw_throughput: got %0d expected 4", obs_q.size()); end
        en1 = 1'b1;
        drive();
        step();
        n_checks++; if ({s_a2, s_a1, s_a0} !== 3'b010) begin n_fail++; $display("FAIL zw_credit_zero: got %b expected 010", {s_a2, s_a1, s_a0}); end
    endtask

    initial begin
        out_a = 1'b1;
        wgt0 = 4'd1; wgt1 = 4'd1; wgt2 = 4'd1;
        en0 = 1'b0; en1 = 1'b0; en2 = 1'b0;
        drive();
        test_reset();
        test_weighted();
        test_pair();
        test_lock();
        test_backpressure();
        test_reset_mid();
        test_zero_weight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_upstream_arbiter.md
PC_UPSTREAM_ARBITER -- requirements
Module: pc_upstream_arbiter

Interface
REQ-001 SHALL have parameter NPCroute, default 5, meaning route field width.
REQ-002 SHALL have parameter NPCcode, default 7, meaning code field width.
REQ-003 SHALL have parameter NPCdata, default 20, meaning payload width; W = NPCroute+NPCcode+NPCdata (default 32), word layout {route, code, data}.
REQ-004 SHALL have parameter NWGT, default 4, meaning weight field width.
REQ-005 SHALL have port clk, input, 1, the single clock.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports in0_d / in0_v / in0_a: input W / input 1 / output 1, the BD stream.
REQ-008 SHALL have ports in1_d / in1_v / in1_a: input W / input 1 / output 1, the FPGA stream.
REQ-009 SHALL have ports in2_d / in2_v / in2_a: input W / input 1 / output 1, the global route stream.
REQ-010 SHALL have ports wgt0, wgt1, wgt2, input, NWGT each, burst weight per source, quasi-static.
REQ-011 SHALL have ports out_d / out_v / out_a: output W / output 1 / input 1, the merged stream to the PC.
REQ-012 SHALL have port cur_src, output, 2, the source index owning the grant.
REQ-013 SHALL have port locked, output, 1, high while a two-word group is in progress.

Function
REQ-014 SHALL complete a transfer on any channel in the cycle where v=1 and a=1.
REQ-015 SHALL register the output in a single word: out_d and out_v come from flops, and the load enable is (!out_v | out_a).
REQ-016 SHALL sustain one word per cycle when out_a is held high; latency from input accept to out_v is 1 cycle.
REQ-017 SHALL decide the grant g combinationally each cycle, as follows.
- If locked=1, then g=cur_src.
- Else, if credit>0 and the input at cur_src is valid, then g=cur_src.
- Else, g is the first valid source in the order cur_src+1, cur_src+2, cur_src (all mod 3).
REQ-018 SHALL drive inN_a = (g==N) & inN_v & (!out_v | out_a); at most one ack is high per cycle.
REQ-019 SHALL, on an accept from a source other than cur_src, set cur_src=g and load credit = max(wgt[g],1)-1.
REQ-020 SHALL, on an accept from cur_src, decrement credit, saturating at 0.
REQ-021 SHALL inspect the accepted word's code field for group locking, as follows.
- Code 15 sets locked.
- Code 16 clears locked.
- Code 14 toggles the pair-phase bit; locked = pair-phase | heartbeat-lock.
REQ-022 SHALL, while locked, hold the grant on cur_src even if other sources are valid, with no timeout.
REQ-023 SHALL hold the grant while locked even when credit is 0, and SHALL NOT decrement credit below 0.
REQ-024 SHALL, when credit is exhausted and no other source is valid, allow cur_src to continue one word at a time with credit 0.
REQ-025 SHALL accept nothing and change no state when no source is valid.
REQ-026 SHALL keep out_d stable while out_v=1 and out_a=0.
REQ-027 SHALL treat a weight change mid-burst as taking effect at the next credit load only.

Reset
REQ-028 SHALL, while reset=0, force out_v=0, out_d=0, cur_src=2, credit=0, locked=0 and pair-phase=0, asynchronously; the first grant after release goes to source 0 if it is valid.
REQ-029 SHALL discard a word held in the output register when reset asserts mid-operation, and SHALL abandon any partial lock group.
REQ-030 SHALL hold all acks at 0 while reset=0.

Verification
REQ-031 SHALL cover: all three sources continuously valid, out_a=1, wgt=(2,1,1) -> output sources 0,0,1,2,0,0,1,2,...
REQ-032 SHALL cover: source 1 sends code-14 words A,B while source 0 is valid; wgt1=1 -> A and B are consecutive on the output, then source 0 is served.
REQ-033 SHALL cover: source 2 sends code 15 and then stalls 10 cycles before sending code 16, while sources 0 and 1 are valid -> no ack to 0 or 1 until code 16 is accepted, and locked=1 throughout.
REQ-034 SHALL cover: out_a=0 for 5 cycles with all sources valid -> out_d is unchanged, exactly one word is accepted, and all acks are 0 thereafter until out_a=1.
REQ-035 SHALL cover: reset asserted while out_v=1 and locked=1 -> out_v=0 and locked=0 immediately; after release, source 0 is granted first.
REQ-036 SHALL cover: wgt0=0 with only source 0 valid -> one word per cycle is accepted, and credit stays at 0.
